// File: rtl/updown_counter.sv
// Parametrised up/down counter with wrap/saturate, load, Gray output.
// Next-state logic feeds a bank of single-bit D flip-flops.
module updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2**WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] gray,
  output logic             terminal,
  output logic             overflow
);

  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   lv;
  logic [WIDTH:0]   next_wide;
  logic [WIDTH-1:0] next_count;
  logic             next_ovf;
  logic             at_max;
  logic             at_zero;
  logic             unused_msb;

  assign ext     = {1'b0, count};
  assign at_max  = (ext == MAX);
  assign at_zero = (count == '0);
  assign lv      = ({1'b0, load_value} > MAX)
                 ? MAX : {1'b0, load_value};

  // Next count and overflow; reset is folded in here so it stays synchronous.
  always_comb begin
    next_wide = ext;
    next_ovf  = 1'b0;
    if (!resetn) begin
      next_wide = '0;
    end else if (load) begin
      next_wide = lv;
    end else if (enable) begin
      if (up) begin
        if (at_max) begin
          next_ovf  = 1'b1;
          next_wide = SATURATE ? ext : '0;
        end else begin
          next_wide = ext + ONE;
        end
      end else begin
        if (at_zero) begin
          next_ovf  = 1'b1;
          next_wide = SATURATE ? ext : MAX;
        end else begin
          next_wide = ext - ONE;
        end
      end
    end
  end

  assign next_count = next_wide[WIDTH-1:0];
  assign unused_msb = next_wide[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    DFlipFlop u_bit (
      .clock (clock),
      .d     (next_count[i]),
      .q     (count[i])
    );
  end

  DFlipFlop u_ovf (
    .clock (clock),
    .d     (next_ovf),
    .q     (overflow)
  );

  assign gray     = count ^ (count >> 1);
  assign terminal = (up & at_max) | (~up & at_zero);

endmodule

module DFlipFlop (
  input  logic clock,
  input  logic d,
  output logic q
);

  // Single storage bit.
  always_ff @(posedge clock) begin
    q <= d;
  end

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter in three configurations.
// Expected values are queued before each edge and popped after it.
module tb_updown_counter;

  logic       clock = 1'b0;
  logic       resetn, enable, up, load;
  logic [3:0] load_value;

  logic [3:0] ca, ga, cb, gb;
  logic       ta, oa, tb2, ob;
  logic [1:0] cc, gc;
  logic       tc, oc;

  always #5 clock = ~clock;

  updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_a (
    .clock(clock), .resetn(resetn), .enable(enable), .up(up),
    .load(load), .load_value(load_value),
    .count(ca), .gray(ga), .terminal(ta), .overflow(oa)
  );

  updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_b (
    .clock(clock), .resetn(resetn), .enable(enable), .up(up),
    .load(load), .load_value(load_value),
    .count(cb), .gray(gb), .terminal(tb2), .overflow(ob)
  );

  updown_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(1'b0)) u_c (
    .clock(clock), .resetn(resetn), .enable(enable), .up(up),
    .load(load), .load_value(load_value[1:0]),
    .count(cc), .gray(gc), .terminal(tc), .overflow(oc)
  );

  typedef struct {
    int         dut;
    logic [3:0] cnt;
    logic       ovf;
    logic       term;
    logic [3:0] gry;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(int dut, int c, logic o, string tag);
    exp_t e;
    int   mx = (dut == 2) ? 3 : 9;
    e.dut  = dut;
    e.cnt  = 4'(c);
    e.ovf  = o;
    e.term = up ? (c == mx) : (c == 0);
    e.gry  = 4'(c ^ (c >> 1));
    e.tag  = tag;
    return e;
  endfunction

  function automatic void obs(input int d, output logic [3:0] c,
                              output logic o, output logic t,
                              output logic [3:0] g);
    case (d)
      0:       begin c = ca; o = oa; t = ta; g = ga; end
      1:       begin c = cb; o = ob; t = tb2; g = gb; end
      default: begin c = {2'b0, cc}; o = oc; t = tc; g = {2'b0, gc}; end
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; load = 1'b0; enable = 1'b0; load_value = '0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [3:0] c, g;
    logic o, t;
    resetn = 1'b0; load = 1'b1; load_value = 4'd3;
    enable = 1'b1; up = 1'b0;
    for (int d = 0; d < 3; d++) sb.push_back(mk(d, 0, 1'b0, "reset"));
    tick();
    for (int d = 0; d < 3; d++) begin
      e = sb.pop_front();
      obs(e.dut, c, o, t, g);
      checks++;
      if ({c, o, t, g} !== {e.cnt, e.ovf, e.term, e.gry}) begin
        errors++;
        $display("FAIL %s dut%0d: got c=%0d o=%b t=%b g=%0d want c=%0d o=%b t=%b g=%0d",
                 e.tag, e.dut, c, o, t, g, e.cnt, e.ovf, e.term, e.gry);
      end
    end
    load = 1'b0; enable = 1'b0; resetn = 1'b1;
  endtask

  task automatic test_wrap_up();
    exp_t e;
    logic [3:0] c, g;
    logic o, t;
    int n;
    do_reset();
    up = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      n = i % 10;
      sb.push_back(mk(0, n, n == 0, "wrap_up"));
      tick();
      e = sb.pop_front();
      obs(e.dut, c, o, t, g);
      checks++;
      if ({c, o, t, g} !== {e.cnt, e.ovf, e.term, e.gry}) begin
        errors++;
        $display("FAIL %s step%0d: got c=%0d o=%b t=%b g=%0d want c=%0d o=%b t=%b g=%0d",
                 e.tag, i, c, o, t, g, e.cnt, e.ovf, e.term, e.gry);
      end
    end
  endtask

  task automatic test_wrap_down();
    exp_t e;
    logic [3:0] c, g;
    logic o, t;
    int n;
    do_reset();
    up = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      n = (10 - (i % 10)) % 10;
      sb.push_back(mk(0, n, n == 9, "wrap_down"));
      tick();
      e = sb.pop_front();
      obs(e.dut, c, o, t, g);
      checks++;
      if ({c, o, t, g} !== {e.cnt, e.ovf, e.term, e.gry}) begin
        errors++;
        $display("FAIL %s step%0d: got c=%0d o=%b t=%b g=%0d want c=%0d o=%b t=%b g=%0d",
                 e.tag, i, c, o, t, g, e.cnt, e.ovf, e.term, e.gry);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    logic [3:0] c, g;
    logic o, t;
    int cs[14];
    logic os[14];
    cs = '{8, 9, 9, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
    os = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      load = (i == 0); load_value = 4'd8;
      enable = (i != 0); up = (i < 4);
      sb.push_back(mk(1, cs[i], os[i], "saturate"));
      tick();
      e = sb.pop_front();
      obs(e.dut, c, o, t, g);
      checks++;
      if ({c, o, t, g} !== {e.cnt, e.ovf, e.term, e.gry}) begin
        errors++;
        $display("FAIL %s step%0d: got c=%0d o=%b t=%b g=%0d want c=%0d o=%b t=%b g=%0d",
                 e.tag, i, c, o, t, g, e.cnt, e.ovf, e.term, e.gry);
      end
    end
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_priority();
    exp_t e;
    logic [3:0] c, g;
    logic o, t;
    logic rs[4], ld[4], en[4];
    int lvs[4], cs[4];
    rs  = '{1, 1, 0, 1};
    ld  = '{1, 1, 1, 0};
    en  = '{0, 1, 1, 1};
    lvs = '{13, 3, 7, 0};
    cs  = '{9, 3, 0, 1};
    do_reset();
    up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      resetn = rs[i]; load = ld[i]; enable = en[i];
      load_value = 4'(lvs[i]);
      sb.push_back(mk(0, cs[i], 1'b0, "priority"));
      tick();
      e = sb.pop_front();
      obs(e.dut, c, o, t, g);
      checks++;
      if ({c, o, t, g} !== {e.cnt, e.ovf, e.term, e.gry}) begin
        errors++;
        $display("FAIL %s step%0d: got c=%0d o=%b t=%b g=%0d want c=%0d o=%b t=%b g=%0d",
                 e.tag, i, c, o, t, g, e.cnt, e.ovf, e.term, e.gry);
      end
    end
    resetn = 1'b1; load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_toggle();
    exp_t e;
    logic [3:0] c, g;
    logic o, t;
    logic us[4], os[4];
    int cs[4];
    us = '{1, 0, 0, 1};
    cs = '{1, 0, 3, 0};
    os = '{0, 0, 1, 1};
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = us[i];
      sb.push_back(mk(2, cs[i], os[i], "toggle"));
      tick();
      e = sb.pop_front();
      obs(e.dut, c, o, t, g);
      checks++;
      if ({c, o, t, g} !== {e.cnt, e.ovf, e.term, e.gry}) begin
        errors++;
        $display("FAIL %s step%0d: got c=%0d o=%b t=%b g=%0d want c=%0d o=%b t=%b g=%0d",
                 e.tag, i, c, o, t, g, e.cnt, e.ovf, e.term, e.gry);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_hold();
    exp_t e;
    logic [3:0] c, g;
    logic o, t;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      load = (i == 0); load_value = 4'd5;
      enable = 1'b0; up = i[0];
      sb.push_back(mk(0, 5, 1'b0, "hold"));
      tick();
      e = sb.pop_front();
      obs(e.dut, c, o, t, g);
      checks++;
      if ({c, o, t, g} !== {e.cnt, e.ovf, e.term, e.gry}) begin
        errors++;
        $display("FAIL %s step%0d: got c=%0d o=%b t=%b g=%0d want c=%0d o=%b t=%b g=%0d",
                 e.tag, i, c, o, t, g, e.cnt, e.ovf, e.term, e.gry);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; up = 1'b0;
    load = 1'b0; load_value = '0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_toggle();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
